// File: rtl/branch_pkg.sv
// Shared constants for the branch predictor: 2-bit counter encodings,
// the default table depth, and the saturating counter step.
package branch_pkg;

    localparam int BHT_DEPTH_DEFAULT = 16;

    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != STRONG_T)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != STRONG_NT)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Direct-mapped branch history table: valid bit, 2-bit saturating counter and
// target per entry. Combinational read port returns the pre-update entry.
module branch_history_table
    import branch_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int DEPTH = BHT_DEPTH_DEFAULT,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [1:0]       rd_ctr,
    output logic [PC_W-1:0]  rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken,
    input  logic [PC_W-1:0]  wr_target
);

    logic            valid_q  [DEPTH];
    logic [1:0]      ctr_q    [DEPTH];
    logic [PC_W-1:0] target_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WEAK_NT;
            end
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            ctr_q[wr_idx]   <= ctr_next(ctr_q[wr_idx], wr_taken);
        end
    end

    // Targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_taken)
            target_q[wr_idx] <= wr_target;
    end

    assign rd_valid  = valid_q[rd_idx];
    assign rd_ctr    = ctr_q[rd_idx];
    assign rd_target = target_q[rd_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-side branch prediction with resolve-stage mispredict redirect.
// Define BRANCH_STATS_EN to add saturating br_count / mispred_count outputs.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int BHT_DEPTH = BHT_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_pc,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [31:0]     ex_imm,
    input  logic            ex_branch,
    input  logic            ex_jalr,
    input  logic [31:0]     ex_alu_result,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_pc,
    output logic [PC_W-1:0] pc_four,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     br_count,
    output logic [15:0]     mispred_count
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic            rd_valid;
    logic [1:0]      rd_ctr;
    logic [PC_W-1:0] rd_target;
    logic            is_cf;
    logic            actual_taken;
    logic [PC_W-1:0] actual_pc;
    logic            mispredict;
    logic            unused_bits;

    branch_history_table #(
        .PC_W  (PC_W),
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (if_pc[IDX_W-1:0]),
        .rd_valid  (rd_valid),
        .rd_ctr    (rd_ctr),
        .rd_target (rd_target),
        .wr_en     (ex_valid & is_cf),
        .wr_idx    (ex_pc[IDX_W-1:0]),
        .wr_taken  (actual_taken),
        .wr_target (actual_pc)
    );

    assign pred_taken = rd_valid & rd_ctr[1];
    assign pred_pc    = pred_taken ? rd_target : if_pc + PC_W'(1);
    assign pc_four    = ex_pc + PC_W'(1);

    assign is_cf        = ex_branch | ex_jalr;
    assign actual_taken = ex_jalr | (ex_branch & ex_alu_result[0]);

    always_comb begin
        actual_pc = pc_four;
        if (ex_jalr)
            actual_pc = ex_alu_result[PC_W-1:0];
        else if (actual_taken)
            actual_pc = ex_pc + ex_imm[PC_W-1:0];
    end

    // A target mismatch only matters when the branch was really taken.
    assign mispredict = ex_valid &
                        ((actual_taken != ex_pred_taken) |
                         (actual_taken & (actual_pc != ex_pred_pc)));

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= mispredict;
            if (mispredict)
                redirect_pc <= actual_pc;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (ex_valid && is_cf && br_count != 16'hFFFF)
                br_count <= br_count + 16'd1;
            if (mispredict && mispred_count != 16'hFFFF)
                mispred_count <= mispred_count + 16'd1;
        end
    end
`endif

    assign unused_bits = &{1'b0, ex_imm[31:PC_W], ex_alu_result[31:PC_W]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus queues expected redirects,
// a monitor compares them one cycle later. Covers BRANCH_STATS_EN when defined.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  if_pc = '0;
    logic        pred_taken;
    logic [7:0]  pred_pc;
    logic        ex_valid = 1'b0;
    logic [7:0]  ex_pc = '0;
    logic [31:0] ex_imm = '0;
    logic        ex_branch = 1'b0;
    logic        ex_jalr = 1'b0;
    logic [31:0] ex_alu_result = '0;
    logic        ex_pred_taken = 1'b0;
    logic [7:0]  ex_pred_pc = '0;
    logic [7:0]  pc_four;
    logic        redirect;
    logic [7:0]  redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_count;
    logic [15:0] mispred_count;
`endif

    typedef struct {
        logic       red;
        logic       chk_pc;
        logic [7:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk           (clk),
        .reset         (reset),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_branch     (ex_branch),
        .ex_jalr       (ex_jalr),
        .ex_alu_result (ex_alu_result),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_pc    (ex_pred_pc),
        .pc_four       (pc_four),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
`ifdef BRANCH_STATS_EN
        ,
        .br_count      (br_count),
        .mispred_count (mispred_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: registered redirect outputs are checked just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("redirect", {31'd0, redirect}, {31'd0, e.red});
            if (e.chk_pc)
                check("redirect_pc", {24'd0, redirect_pc}, {24'd0, e.pc});
        end
    end

    task automatic step(input logic rst, input logic [7:0] ifpc,
                        input logic v, input logic br, input logic jl,
                        input logic [7:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                        input logic pt, input logic [7:0] ppc,
                        input logic er, input logic ck, input logic [7:0] epc);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        if_pc         = ifpc;
        ex_valid      = v;
        ex_branch     = br;
        ex_jalr       = jl;
        ex_pc         = pc;
        ex_imm        = imm;
        ex_alu_result = alu;
        ex_pred_taken = pt;
        ex_pred_pc    = ppc;
        e.red = er;
        e.chk_pc = ck;
        e.pc = epc;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input logic [7:0] ifpc);
        step(0, ifpc, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic check_pred(input string name, input logic et, input logic [7:0] epc);
        check({name, "_taken"}, {31'd0, pred_taken}, {31'd0, et});
        check({name, "_pc"}, {24'd0, pred_pc}, {24'd0, epc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        step(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'h00);
        step(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'h00);

        idle(8'h05);
        check_pred("reset_pred", 1'b0, 8'h06);

        // Taken branch predicted not-taken
        step(0, 8'h00, 1, 1, 0, 8'h10, 32'd4, 32'd1, 0, 8'h11, 1, 1, 8'h14);
        check("pc_four_10", {24'd0, pc_four}, 32'h11);
        idle(8'h10);
        check_pred("after_first_taken", 1'b1, 8'h14);

        step(0, 8'h00, 1, 1, 0, 8'h10, 32'd4, 32'd1, 1, 8'h14, 0, 0, 8'h00);
        step(0, 8'h00, 1, 1, 0, 8'h10, 32'd4, 32'd1, 1, 8'h14, 0, 0, 8'h00);
        // Counter saturated at 3: one not-taken leaves it weakly taken
        step(0, 8'h00, 1, 1, 0, 8'h10, 32'd4, 32'd0, 1, 8'h14, 1, 1, 8'h11);
        idle(8'h10);
        check_pred("ctr_2", 1'b1, 8'h14);
        step(0, 8'h00, 1, 1, 0, 8'h10, 32'd4, 32'd0, 1, 8'h14, 1, 1, 8'h11);
        idle(8'h10);
        check_pred("ctr_1", 1'b0, 8'h11);

        // jalr with PC wrap
        step(0, 8'h00, 1, 0, 1, 8'hFF, 32'd0, 32'h0000_0123, 0, 8'h00, 1, 1, 8'h23);
        check("pc_four_wrap", {24'd0, pc_four}, 32'h00);
        idle(8'hFF);
        check_pred("jalr_entry", 1'b1, 8'h23);

        // Non-branch: mispredicts only when predicted taken, never updates
        step(0, 8'h00, 1, 0, 0, 8'h30, 32'd0, 32'd1, 1, 8'h31, 1, 1, 8'h31);
        step(0, 8'h30, 1, 0, 0, 8'h30, 32'd0, 32'd1, 0, 8'h31, 0, 0, 8'h00);
        check_pred("nonbranch_no_update", 1'b0, 8'h31);

        // Right direction, wrong target
        step(0, 8'h00, 1, 1, 0, 8'h20, 32'd8, 32'd1, 1, 8'h29, 1, 1, 8'h28);
        idle(8'h20);
        check_pred("target_written", 1'b1, 8'h28);

        // Same-cycle read and write of index 3 returns the old entry
        step(0, 8'h03, 1, 1, 0, 8'h03, 32'd5, 32'd1, 0, 8'h04, 1, 1, 8'h08);
        check_pred("read_old", 1'b0, 8'h04);
        idle(8'h03);
        check_pred("read_new", 1'b1, 8'h08);

        // Correct not-taken: no redirect, target untouched
        step(0, 8'h00, 1, 1, 0, 8'h44, 32'd9, 32'd0, 0, 8'h45, 0, 0, 8'h00);
        idle(8'h44);
        check_pred("nt_correct", 1'b0, 8'h45);

        // Reset during the redirect cycle, with a simultaneous update
        step(0, 8'h00, 1, 1, 0, 8'h40, 32'd2, 32'd1, 0, 8'h41, 1, 1, 8'h42);
        step(1, 8'h00, 1, 1, 0, 8'h03, 32'd5, 32'd1, 0, 8'h04, 0, 1, 8'h00);
        idle(8'h03);
        check_pred("post_reset_03", 1'b0, 8'h04);
        idle(8'hFF);
        check_pred("post_reset_ff", 1'b0, 8'h00);
        idle(8'h20);
        check_pred("post_reset_20", 1'b0, 8'h21);

`ifdef BRANCH_STATS_EN
        check("br_count_reset", {16'd0, br_count}, 32'd0);
        check("mispred_count_reset", {16'd0, mispred_count}, 32'd0);
        step(0, 8'h00, 1, 1, 0, 8'h05, 32'd1, 32'd0, 0, 8'h06, 0, 0, 8'h00);
        step(0, 8'h00, 1, 1, 0, 8'h06, 32'd1, 32'd0, 0, 8'h07, 0, 0, 8'h00);
        step(0, 8'h00, 1, 1, 0, 8'h07, 32'd1, 32'd1, 0, 8'h08, 1, 1, 8'h08);
        idle(8'h00);
        check("br_count", {16'd0, br_count}, 32'd3);
        check("mispred_count", {16'd0, mispred_count}, 32'd1);
`endif

        idle(8'h00);
        idle(8'h00);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
